// File: rtl/uart_pkg.sv
// Shared definitions for the UART framer and the matching receive-side deframer.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_LEN  = 3'd2,
    ST_PAY  = 3'd3,
    ST_CSUM = 3'd4
  } framer_state_e;

  localparam logic [7:0] DEFAULT_HEADER_BYTE = 8'hA5;

endpackage

// File: rtl/uart_tx_framer_if.sv
// Payload-in / byte-out handshake bundle between the framer and its neighbours.
interface uart_tx_framer_if #(
  parameter int PAYLOAD_BYTES = 4
);
  logic [8*PAYLOAD_BYTES-1:0] payload;
  logic                       in_valid;
  logic                       in_ready;
  logic [7:0]                 tx_data;
  logic                       tx_valid;
  logic                       tx_ready;
  logic                       busy;

  modport master (
    output payload, in_valid, tx_ready,
    input  in_ready, tx_data, tx_valid, busy
  );

  modport slave (
    input  payload, in_valid, tx_ready,
    output in_ready, tx_data, tx_valid, busy
  );
endinterface

// File: rtl/uart_tx_framer.sv
// Wraps a fixed-size payload into HEADER, LEN, payload bytes, CSUM and streams it
// byte by byte to a UART transmitter with valid/ready flow control.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int         PAYLOAD_BYTES = 4,
  parameter logic [7:0] HEADER_BYTE   = DEFAULT_HEADER_BYTE
) (
  input logic              clk,
  input logic              rst,
  uart_tx_framer_if.slave  bus
);

  localparam int                 IDX_W    = $clog2(PAYLOAD_BYTES) + 1;
  localparam logic [7:0]         LEN_BYTE = 8'(PAYLOAD_BYTES);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(PAYLOAD_BYTES);

  framer_state_e              state_q,    state_d;
  logic [8*PAYLOAD_BYTES-1:0] shift_q,    shift_d;
  logic [IDX_W-1:0]           idx_q,      idx_d;
  logic [7:0]                 csum_q,     csum_d;
  logic [7:0]                 tx_data_q,  tx_data_d;
  logic                       tx_valid_q, tx_valid_d;
  logic                       in_ready_q, in_ready_d;
  logic                       busy_q,     busy_d;
  logic                       consume;

  assign consume = tx_valid_q && bus.tx_ready;

  // idx_q counts bytes already presented; csum_q folds in each byte as it is
  // presented, so it is complete by the time the last payload byte is consumed.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    csum_d     = csum_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    in_ready_d = in_ready_q;
    busy_d     = busy_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_d    = ST_HDR;
          shift_d    = bus.payload;
          idx_d      = '0;
          csum_d     = 8'h00;
          tx_data_d  = HEADER_BYTE;
          tx_valid_d = 1'b1;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      ST_HDR: begin
        if (consume) begin
          state_d   = ST_LEN;
          tx_data_d = LEN_BYTE;
          csum_d    = LEN_BYTE;
        end
      end
      ST_LEN: begin
        if (consume) begin
          state_d   = ST_PAY;
          tx_data_d = shift_q[7:0];
          csum_d    = csum_q ^ shift_q[7:0];
          shift_d   = shift_q >> 8;
          idx_d     = IDX_W'(1);
        end
      end
      ST_PAY: begin
        if (consume) begin
          if (idx_q == LAST_IDX) begin
            state_d   = ST_CSUM;
            tx_data_d = csum_q;
          end else begin
            tx_data_d = shift_q[7:0];
            csum_d    = csum_q ^ shift_q[7:0];
            shift_d   = shift_q >> 8;
            idx_d     = idx_q + IDX_W'(1);
          end
        end
      end
      ST_CSUM: begin
        if (consume) begin
          state_d    = ST_IDLE;
          idx_d      = '0;
          csum_d     = 8'h00;
          tx_data_d  = 8'h00;
          tx_valid_d = 1'b0;
          in_ready_d = 1'b1;
          busy_d     = 1'b0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        idx_d      = '0;
        csum_d     = 8'h00;
        tx_data_d  = 8'h00;
        tx_valid_d = 1'b0;
        in_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      csum_q     <= 8'h00;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      csum_q     <= csum_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.in_ready = in_ready_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: reset, basic frame, backpressure, back-to-back,
// mid-frame reset, ignored input and a single-byte-payload instance.
module tb_uart_tx_framer;
  import uart_pkg::*;

  typedef logic [7:0] frame_t [7];

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  uart_tx_framer_if #(.PAYLOAD_BYTES(4)) bus  ();
  uart_tx_framer_if #(.PAYLOAD_BYTES(1)) bus1 ();

  uart_tx_framer #(.PAYLOAD_BYTES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  uart_tx_framer #(.PAYLOAD_BYTES(1), .HEADER_BYTE(8'h3C)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tx_valid"}, 32'(bus.tx_valid), 32'd0);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_busy"},     32'(bus.busy),     32'd0);
  endtask

  // Walks one frame starting with the header visible; optional stall on one byte,
  // optional noise on the input side while the frame is in flight.
  task automatic expect_frame(input string tag, input frame_t exp, input int stall_idx,
                              input int stall_cycles, input bit noise, input bit end_idle);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("%s_v%0d", tag, i),  32'(bus.tx_valid), 32'd1);
      check($sformatf("%s_b%0d", tag, i),  32'(bus.tx_data),  32'(exp[i]));
      check($sformatf("%s_bz%0d", tag, i), 32'(bus.busy),     32'd1);
      check($sformatf("%s_ir%0d", tag, i), 32'(bus.in_ready), 32'd0);
      if (i == stall_idx) begin
        bus.tx_ready = 1'b0;
        for (int k = 0; k < stall_cycles; k++) begin
          step();
          check($sformatf("%s_sv%0d", tag, k), 32'(bus.tx_valid), 32'd1);
          check($sformatf("%s_sb%0d", tag, k), 32'(bus.tx_data),  32'(exp[i]));
        end
        bus.tx_ready = 1'b1;
      end
      if (noise) begin
        bus.in_valid = (i == 6) ? 1'b0 : 1'($urandom_range(0, 1));
        bus.payload  = $urandom;
      end
      step();
    end
    if (end_idle) check_idle({tag, "_end"});
  endtask

  initial begin
    frame_t f_basic = '{8'hA5, 8'h04, 8'h78, 8'h56, 8'h34, 8'h12, 8'h0C};
    frame_t f_zero  = '{8'hA5, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04};
    frame_t f_ones  = '{8'hA5, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h04};
    frame_t f_mix   = '{8'hA5, 8'h04, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h26};
    logic [7:0] f_one [4] = '{8'h3C, 8'h01, 8'h5A, 8'h5B};

    rst           = 1'b1;
    bus.payload   = '0;
    bus.in_valid  = 1'b0;
    bus.tx_ready  = 1'b1;
    bus1.payload  = '0;
    bus1.in_valid = 1'b0;
    bus1.tx_ready = 1'b1;

    // Reset state
    step();
    step();
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_tx_data",  32'(bus.tx_data),  32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_busy",     32'(bus.busy),     32'd0);
    rst = 1'b0;
    step();
    check_idle("post_rst");

    // Basic frame with ready held high
    bus.payload  = 32'h12345678;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    expect_frame("basic", f_basic, -1, 0, 1'b0, 1'b1);

    // Backpressure on byte 0x56 for 10 cycles
    bus.payload  = 32'h12345678;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    expect_frame("bp", f_basic, 3, 10, 1'b0, 1'b1);

    // Back-to-back with in_valid held high; second payload set after first capture
    bus.payload  = 32'h00000000;
    bus.in_valid = 1'b1;
    step();
    bus.payload  = 32'hFFFFFFFF;
    expect_frame("b2b0", f_zero, -1, 0, 1'b0, 1'b0);
    check("b2b_gap_valid", 32'(bus.tx_valid), 32'd0);
    check("b2b_gap_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    expect_frame("b2b1", f_ones, -1, 0, 1'b0, 1'b1);

    // Reset mid-frame after 0x78 is consumed
    bus.payload  = 32'h12345678;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    step();
    check("mid_pre_data", 32'(bus.tx_data), 32'h56);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("mid_rst");
    check("mid_rst_data", 32'(bus.tx_data), 32'd0);
    step();
    step();
    check_idle("mid_noresume");
    // Payload offered in the first cycle after reset is taken
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.payload  = 32'h12345678;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    expect_frame("after_rst", f_basic, -1, 0, 1'b0, 1'b1);

    // Input noise during a frame is ignored, and no extra frame follows
    bus.payload  = 32'hDEADBEEF;
    bus.in_valid = 1'b1;
    step();
    expect_frame("noise", f_mix, 2, 3, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("noise_quiet%0d", k), 32'(bus.tx_valid), 32'd0);
    end

    // Single-byte payload with pulsed ready (one high cycle, two low per byte)
    bus1.payload  = 8'h5A;
    bus1.in_valid = 1'b1;
    bus1.tx_ready = 1'b0;
    step();
    bus1.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("p1_v%0d_%0d", i, k), 32'(bus1.tx_valid), 32'd1);
        check($sformatf("p1_b%0d_%0d", i, k), 32'(bus1.tx_data),  32'(f_one[i]));
        step();
      end
      bus1.tx_ready = 1'b1;
      step();
      bus1.tx_ready = 1'b0;
    end
    check("p1_end_valid", 32'(bus1.tx_valid), 32'd0);
    check("p1_end_ready", 32'(bus1.in_ready), 32'd1);
    check("p1_end_busy",  32'(bus1.busy),     32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 Parameter PAYLOAD_BYTES, default 4: number of payload bytes per frame, legal range 1..255.
REQ-002 Parameter HEADER_BYTE, default 8'hA5: sync byte that opens every frame.
REQ-003 Port clk  input  1: single clock; all logic is on its rising edge.
REQ-004 Port rst  input  1: reset, synchronous and active-high.
REQ-005 Port payload  input  8*PAYLOAD_BYTES: frame payload; byte 0 is payload[7:0].
REQ-006 Port in_valid  input  1: payload is valid.
REQ-007 Port in_ready  output  1: framer is idle and accepts a payload.
REQ-008 Port tx_data  output  8: byte presented to the downstream UART transmitter.
REQ-009 Port tx_valid  output  1: tx_data is valid.
REQ-010 Port tx_ready  input  1: downstream transmitter accepts a byte.
REQ-011 Port busy  output  1: a frame is in progress.

Function
REQ-012 The block is a single clock domain (clk), with synchronous active-high reset rst.
REQ-013 Frame format, in transmit order: HEADER_BYTE, LEN (= PAYLOAD_BYTES[7:0]), payload byte 0 .. PAYLOAD_BYTES-1, CSUM.
REQ-014 CSUM is the 8-bit XOR of LEN and all payload bytes; HEADER_BYTE is excluded.
REQ-015 Input handshake: a payload is captured into an internal register on a clk edge where in_valid && in_ready.
REQ-016 Output handshake: a byte is consumed on a clk edge where tx_valid && tx_ready.
REQ-017 tx_data stays stable while tx_valid=1 && tx_ready=0.
REQ-018 tx_valid is never withdrawn before the handshake completes.
REQ-019 FSM states and transitions:
- IDLE -> HDR on input capture.
- HDR -> LEN on consume.
- LEN -> PAY on consume.
- PAY stays in PAY, incrementing the byte index on each consume; PAY -> CSUM when the last byte is consumed.
- CSUM -> IDLE on consume.
REQ-020 Undefined state encodings return to IDLE.
REQ-021 Latency: if the capture happens on edge N, tx_valid=1 with tx_data=HEADER_BYTE from edge N (visible in cycle N+1).
REQ-022 After each consume, the next byte is presented on the same edge, so there is no bubble cycle.
REQ-023 in_ready=1 only in IDLE.
REQ-024 in_ready deasserts on the capture edge and reasserts on the edge that consumes CSUM.
REQ-025 busy = (state != IDLE).
REQ-026 All outputs are registered.
REQ-027 The running checksum is accumulated as each byte is presented, so no combinational XOR tree spans the full payload.
REQ-028 The byte index is $clog2(PAYLOAD_BYTES)+1 bits wide and never wraps within a frame.
REQ-029 in_valid while not IDLE is ignored, and payload changes after capture have no effect on the current frame.
REQ-030 With PAYLOAD_BYTES=1, PAY lasts exactly one byte.
REQ-031 tx_ready may be held high continuously, or may pulse high-then-low per byte; the transmitter drops ready for the whole symbol time, and both patterns are legal.

Reset
REQ-032 While rst=1: state=IDLE, tx_valid=0, tx_data=8'h00, busy=0, in_ready=1, byte index=0, checksum=0.
REQ-033 Reset asserted mid-frame aborts the frame immediately.
REQ-034 No partial frame resumes after reset.
REQ-035 A payload presented in the first cycle after reset is accepted.

Structure
REQ-036 Package uart_pkg holds the framer state enum typedef and the default HEADER_BYTE constant, for reuse by the matching receive-side deframer.
REQ-037 The block is a single module with no sub-module.
REQ-038 The framer's tx_* ports connect directly to the UART transmitter's data/valid/ready.

Verification
REQ-039 Basic frame: PAYLOAD_BYTES=4, payload=32'h12345678, tx_ready=1 -> bytes A5,04,78,56,34,12,0C on consecutive cycles; then in_ready=1.
REQ-040 Backpressure: same frame with tx_ready=0 for 10 cycles while byte 0x56 is presented -> tx_data=0x56 and tx_valid=1 held throughout; output sequence unchanged.
REQ-041 Back-to-back: in_valid held high with payloads 32'h00000000 then 32'hFFFFFFFF -> A5,04,00,00,00,00,04 then A5,04,FF,FF,FF,FF,04, with header 2 presented on the edge after CSUM 1 is consumed plus one capture cycle.
REQ-042 Reset mid-frame: rst=1 for one cycle after byte 0x78 is consumed -> next cycle tx_valid=0, in_ready=1, busy=0; a subsequent payload 32'h12345678 yields a complete, correct frame.
REQ-043 Ignored input: toggle in_valid and payload during a frame -> the frame bytes match the captured payload, and no extra frame is produced.
REQ-044 Loopback: framer + UART transmitter at 115200 baud / 100 MHz -> the serial line decodes to A5,04,78,56,34,12,0C with one stop bit each.
